race_flow_controller: RTL

- Game-level sequencer that sits beside the pixel compositor.
- Accumulates per-pixel collision flags during each frame and decides the game state at every frame boundary.
- Drives speed, score and fuel, plus the sprite-layer enables and message-board select that the compositor and sprite blocks consume.
- All decisions are frame-synchronous (on startOfFrame); collision capture is pixel-rate.

---
 rtl/race_pkg.sv | 60 ++++++
 rtl/race_flow_controller_collision_latch.sv | 60 ++++++
 rtl/race_flow_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared types and constants for the race game sequencer and the compositor.
package race_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned FUEL_W  = 7;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned LAYER_W = 6;
  localparam int unsigned MSG_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RACE      = 3'd2,
    ST_CRASH     = 3'd3,
    ST_FINISH    = 3'd4,
    ST_GAMEOVER  = 3'd5
  } state_e;

  typedef enum logic [MSG_W-1:0] {
    MSG_NONE  = 2'd0,
    MSG_TITLE = 2'd1,
    MSG_WIN   = 2'd2,
    MSG_LOSE  = 2'd3
  } msg_e;

  // Sprite-layer bit positions in layer_en, shared with the compositor.
  localparam int unsigned LAYER_PLAYER = 0;
  localparam int unsigned LAYER_AI     = 1;
  localparam int unsigned LAYER_TRUCK  = 2;
  localparam int unsigned LAYER_BONUS  = 3;
  localparam int unsigned LAYER_AI_RED = 4;
  localparam int unsigned LAYER_FINISH = 5;

  localparam logic [LAYER_W-1:0] LAYERS_ALL = LAYER_W'((1 << LAYER_PLAYER) | (1 << LAYER_AI) |
                                                       (1 << LAYER_TRUCK)  | (1 << LAYER_BONUS) |
                                                       (1 << LAYER_AI_RED) | (1 << LAYER_FINISH));
  localparam logic [LAYER_W-1:0] LAYERS_NONE = '0;

  // Player sprite blink half-period while crashed, in frames.
  localparam int unsigned BLINK_FRAMES = 4;

  // Per-frame collision summary.
  typedef struct packed {
    logic finish;
    logic bonus;
    logic road_edge;
    logic truck;
    logic ai;
  } hits_t;

  // Score addition saturating at all-ones.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/race_flow_controller_collision_latch.sv
// Pixel-rate collision and start-key capture, snapshotted once per frame.
module collision_latch
  import race_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  startOfFrame,
  input  logic  start_key,
  input  logic  col_ai,
  input  logic  col_truck,
  input  logic  col_edge,
  input  logic  col_bonus,
  input  logic  col_finish,
  output hits_t frame_hits,
  output logic  start_flag,
  output logic  frame_tick
);

  hits_t sticky_q;
  hits_t col_now;
  logic  start_q;
  logic  start_latch_q;
  logic  start_rise;

  // Current-pixel collisions packed into the frame summary layout.
  always_comb begin
    col_now           = '0;
    col_now.ai        = col_ai;
    col_now.truck     = col_truck;
    col_now.road_edge = col_edge;
    col_now.bonus     = col_bonus;
    col_now.finish    = col_finish;
    start_rise        = start_key & ~start_q;
  end

  // Sticky accumulation; a boundary-cycle event belongs to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q      <= '0;
      frame_hits    <= '0;
      start_q       <= 1'b0;
      start_latch_q <= 1'b0;
      start_flag    <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      start_q    <= start_key;
      frame_tick <= startOfFrame;
      if (startOfFrame) begin
        frame_hits    <= sticky_q;
        sticky_q      <= col_now;
        start_flag    <= start_latch_q;
        start_latch_q <= start_rise;
      end else begin
        sticky_q      <= sticky_q | col_now;
        start_latch_q <= start_latch_q | start_rise;
      end
    end
  end

endmodule

// File: rtl/race_flow_controller.sv
// Frame-synchronous game sequencer: state, speed, fuel, score and sprite control.
module race_flow_controller
  import race_pkg::*;
#(
  parameter int unsigned COUNT_FRAMES = 90,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned ACCEL_FRAMES = 4,
  parameter int unsigned FUEL_FRAMES  = 30,
  parameter int unsigned MAX_SPEED    = 15,
  parameter int unsigned FUEL_INIT    = 100,
  parameter int unsigned FUEL_MAX     = 127,
  parameter int unsigned BONUS_FUEL   = 20,
  parameter int unsigned BONUS_SCORE  = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_key,
  input  logic               accel_key,
  input  logic               col_ai,
  input  logic               col_truck,
  input  logic               col_edge,
  input  logic               col_bonus,
  input  logic               col_finish,
  output logic [STATE_W-1:0] game_state,
  output logic [SPEED_W-1:0] speed,
  output logic [FUEL_W-1:0]  fuel,
  output logic [SCORE_W-1:0] score,
  output logic [LAYER_W-1:0] layer_en,
  output logic [MSG_W-1:0]   msg_sel,
  output logic               bonus_clear
);

  localparam int unsigned CNT_MAX = (COUNT_FRAMES > CRASH_FRAMES) ? COUNT_FRAMES : CRASH_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ACC_W   = $clog2(ACCEL_FRAMES + 1);
  localparam int unsigned FC_W    = $clog2(FUEL_FRAMES + 1);

  hits_t frame_hits;
  logic  start_flag;
  logic  frame_tick;

  state_e             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FUEL_W-1:0]  fuel_q, fuel_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  msg_e               msg_q, msg_d;
  logic               bc_q, bc_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ACC_W-1:0]   accel_cnt_q, accel_cnt_d;
  logic [FC_W-1:0]    fuel_cnt_q, fuel_cnt_d;

  logic               crash_hit;
  logic [FUEL_W:0]    fuel_sum;
  logic [FUEL_W-1:0]  fuel_w;
  logic [SCORE_W-1:0] score_w;

  collision_latch u_collision_latch (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .start_key    (start_key),
    .col_ai       (col_ai),
    .col_truck    (col_truck),
    .col_edge     (col_edge),
    .col_bonus    (col_bonus),
    .col_finish   (col_finish),
    .frame_hits   (frame_hits),
    .start_flag   (start_flag),
    .frame_tick   (frame_tick)
  );

  // State and all game registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      speed_q     <= '0;
      fuel_q      <= '0;
      score_q     <= '0;
      layer_q     <= LAYERS_NONE;
      msg_q       <= MSG_TITLE;
      bc_q        <= 1'b0;
      frame_cnt_q <= '0;
      accel_cnt_q <= '0;
      fuel_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      fuel_q      <= fuel_d;
      score_q     <= score_d;
      layer_q     <= layer_d;
      msg_q       <= msg_d;
      bc_q        <= bc_d;
      frame_cnt_q <= frame_cnt_d;
      accel_cnt_q <= accel_cnt_d;
      fuel_cnt_q  <= fuel_cnt_d;
    end
  end

  // Next-state and per-frame game rules; everything advances only on frame_tick.
  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    fuel_d      = fuel_q;
    score_d     = score_q;
    layer_d     = layer_q;
    msg_d       = msg_q;
    bc_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    accel_cnt_d = accel_cnt_q;
    fuel_cnt_d  = fuel_cnt_q;
    crash_hit   = frame_hits.ai | frame_hits.truck | frame_hits.road_edge;
    fuel_sum    = {1'b0, fuel_q} + (FUEL_W+1)'(BONUS_FUEL);
    fuel_w      = fuel_q;
    score_w     = score_q;

    case (state_q)
      ST_IDLE: begin
        msg_d   = MSG_TITLE;
        layer_d = LAYERS_NONE;
        speed_d = '0;
        if (frame_tick && start_flag) begin
          state_d     = ST_COUNTDOWN;
          fuel_d      = FUEL_W'(FUEL_INIT);
          score_d     = '0;
          frame_cnt_d = '0;
          accel_cnt_d = '0;
          fuel_cnt_d  = '0;
          layer_d     = LAYERS_ALL;
          msg_d       = MSG_NONE;
        end
      end

      ST_COUNTDOWN: begin
        layer_d = LAYERS_ALL;
        msg_d   = MSG_NONE;
        if (frame_tick) begin
          if (frame_cnt_q == CNT_W'(COUNT_FRAMES - 1)) begin
            state_d     = ST_RACE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RACE: begin
        if (frame_tick) begin
          if (frame_hits.finish) begin
            state_d = ST_FINISH;
            msg_d   = MSG_WIN;
            speed_d = '0;
          end else if (fuel_q == '0) begin
            state_d = ST_GAMEOVER;
            msg_d   = MSG_LOSE;
            speed_d = '0;
          end else begin
            // Distance score uses the speed held during the frame just ended.
            score_w = score_add(score_q, SCORE_W'(speed_q));
            if (frame_hits.bonus) begin
              fuel_w  = (fuel_sum > (FUEL_W+1)'(FUEL_MAX)) ? FUEL_W'(FUEL_MAX) : fuel_sum[FUEL_W-1:0];
              score_w = score_add(score_w, SCORE_W'(BONUS_SCORE));
              bc_d    = 1'b1;
            end
            if (fuel_cnt_q == FC_W'(FUEL_FRAMES - 1)) begin
              fuel_cnt_d = '0;
              if (fuel_w != '0) fuel_w = fuel_w - FUEL_W'(1);
            end else begin
              fuel_cnt_d = fuel_cnt_q + FC_W'(1);
            end
            fuel_d  = fuel_w;
            score_d = score_w;

            if (crash_hit) begin
              state_d     = ST_CRASH;
              speed_d     = '0;
              frame_cnt_d = '0;
              accel_cnt_d = '0;
              layer_d     = LAYERS_ALL;
            end else if (accel_key) begin
              if (accel_cnt_q == ACC_W'(ACCEL_FRAMES - 1)) begin
                accel_cnt_d = '0;
                if (speed_q < SPEED_W'(MAX_SPEED)) speed_d = speed_q + SPEED_W'(1);
              end else begin
                accel_cnt_d = accel_cnt_q + ACC_W'(1);
              end
            end else begin
              accel_cnt_d = '0;
              if (speed_q != '0) speed_d = speed_q - SPEED_W'(1);
            end
          end
        end
      end

      ST_CRASH: begin
        speed_d = '0;
        if (frame_tick) begin
          if (frame_cnt_q == CNT_W'(CRASH_FRAMES - 1)) begin
            frame_cnt_d           = '0;
            layer_d               = LAYERS_ALL;
            layer_d[LAYER_PLAYER] = 1'b1;
            if (fuel_q == '0) begin
              state_d = ST_GAMEOVER;
              msg_d   = MSG_LOSE;
            end else begin
              state_d = ST_RACE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            layer_d     = {LAYERS_ALL[LAYER_W-1:1], layer_q[LAYER_PLAYER]};
            if (frame_cnt_q[1:0] == 2'(BLINK_FRAMES - 1))
              layer_d[LAYER_PLAYER] = ~layer_q[LAYER_PLAYER];
          end
        end
      end

      ST_FINISH, ST_GAMEOVER: begin
        msg_d   = (state_q == ST_FINISH) ? MSG_WIN : MSG_LOSE;
        speed_d = '0;
        if (frame_tick && start_flag) begin
          state_d = ST_IDLE;
          msg_d   = MSG_TITLE;
          layer_d = LAYERS_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        msg_d   = MSG_TITLE;
        layer_d = LAYERS_NONE;
        speed_d = '0;
      end
    endcase
  end

  assign game_state  = state_q;
  assign speed       = speed_q;
  assign fuel        = fuel_q;
  assign score       = score_q;
  assign layer_en    = layer_q;
  assign msg_sel     = msg_q;
  assign bonus_clear = bc_q;

endmodule
